// File: rtl/gray_display_pkg.sv
// Shared types and constants for the Gray switch to LED / seven-segment
// display path.
package gray_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_e;

  // Segments a..g, bit 6 = a, active-high
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic int nib_count(int digits);
    return digits;
  endfunction

endpackage

// File: rtl/gray_display_scan_seg7.sv
// Nibble to seven-segment decoder; non-BCD codes and blank give all-off.
module seg7_decode
  import gray_display_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (nib_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/gray_display_scan.sv
// Debounced Gray switch input -> binary LEDs plus double-dabble BCD
// conversion scanned onto a multiplexed seven-segment display.
module gray_display_scan
  import gray_display_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int DIGITS        = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int REFRESH_DIV   = 8,
  parameter int BLANK_LZ      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  gray_in,
  output logic [WIDTH-1:0]  led,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              bcd_valid
);

  localparam int NB = 4 * nib_count(DIGITS);
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int TW = NB + WIDTH;

  logic [WIDTH-1:0]  sync1_q, sync2_q, prev_q, acc_q, led_q;
  logic [SW-1:0]     stab_q, stab_d;
  logic [WIDTH-1:0]  bin;
  logic              same, sat, accept;
  state_e            state_q, state_d;
  logic [TW-1:0]     sh_q, sh_d, adj, shifted;
  logic [CW-1:0]     step_q, step_d;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic              pend_v_q, pend_v_d;
  logic [NB-1:0]     disp_q, disp_d;
  logic              vld_q, vld_d;
  logic [RW-1:0]     ref_q, ref_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q, seg_w;
  logic [3:0]        nib;
  logic              blank, zero_hi, wrap;

  always_comb begin
    bin = '0;
    bin[WIDTH-1] = sync2_q[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) bin[i] = bin[i+1] ^ sync2_q[i];
  end

  assign same   = (sync2_q == prev_q);
  assign sat    = (stab_q == SW'(STABLE_CYCLES - 1));
  assign accept = same && sat && (sync2_q != acc_q);
  assign stab_d = !same ? '0 : (sat ? stab_q : stab_q + 1'b1);

  always_comb begin
    adj = sh_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[WIDTH+4*k +: 4] >= 4'd5)
        adj[WIDTH+4*k +: 4] = adj[WIDTH+4*k +: 4] + 4'd3;
    end
    shifted = {adj[TW-2:0], 1'b0};
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    step_d   = step_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    disp_d   = disp_q;
    vld_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = {{NB{1'b0}}, bin};
          step_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d   = shifted;
        step_d = step_q + 1'b1;
        if (step_q == CW'(WIDTH - 1)) state_d = LOAD;
        if (accept) begin
          pend_d   = bin;
          pend_v_d = 1'b1;
        end
      end
      LOAD: begin
        disp_d  = sh_q[TW-1:WIDTH];
        vld_d   = 1'b1;
        state_d = IDLE;
        // A value accepted this very cycle supersedes the pending one
        if (accept || pend_v_q) begin
          sh_d     = {{NB{1'b0}}, accept ? bin : pend_q};
          step_d   = '0;
          pend_v_d = 1'b0;
          state_d  = CONV;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wrap  = (ref_q == RW'(REFRESH_DIV - 1));
  assign ref_d = wrap ? '0 : ref_q + 1'b1;
  assign idx_d = !wrap ? idx_q :
                 (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    nib     = '0;
    blank   = 1'b0;
    zero_hi = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_hi = zero_hi && (disp_q[4*k +: 4] == 4'd0);
      if (IW'(k) == idx_q) begin
        nib   = disp_q[4*k +: 4];
        blank = (BLANK_LZ != 0) && (k != 0) && zero_hi;
      end
    end
  end

  seg7_decode u_dec (
    .nib_i   (nib),
    .blank_i (blank),
    .seg_o   (seg_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      acc_q    <= '0;
      led_q    <= '0;
      stab_q   <= '0;
      state_q  <= IDLE;
      sh_q     <= '0;
      step_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      vld_q    <= 1'b0;
      ref_q    <= '0;
      idx_q    <= '0;
      an_q     <= '1;
      seg_q    <= '0;
    end else begin
      sync1_q  <= gray_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      stab_q   <= stab_d;
      if (accept) begin
        acc_q <= sync2_q;
        led_q <= bin;
      end
      state_q  <= state_d;
      sh_q     <= sh_d;
      step_q   <= step_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      vld_q    <= vld_d;
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      an_q     <= ~(DIGITS'(1) << idx_q);
      seg_q    <= seg_w;
    end
  end

  assign led       = led_q;
  assign seg       = seg_q;
  assign an        = an_q;
  assign bcd_valid = vld_q;

endmodule

// File: tb/tb_gray_display_scan.sv
// Bench for gray_display_scan: default instance plus a fast-accept
// instance used to overlap acceptances with a running conversion.
module tb_gray_display_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] gray_in = '0;
  logic [3:0] led;
  logic [6:0] seg;
  logic [1:0] an;
  logic       bcd_valid;
  logic [3:0] gray_b = '0;
  logic [3:0] led_b;
  logic [6:0] seg_b;
  logic [1:0] an_b;
  logic       bcd_valid_b;

  int checks = 0;
  int failures = 0;
  int exp_led_q[$];
  int exp_disp_q[$];

  always #5 clk = ~clk;

  gray_display_scan dut (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_in),
    .led       (led),
    .seg       (seg),
    .an        (an),
    .bcd_valid (bcd_valid)
  );

  gray_display_scan #(.STABLE_CYCLES(1)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .gray_in   (gray_b),
    .led       (led_b),
    .seg       (seg_b),
    .an        (an_b),
    .bcd_valid (bcd_valid_b)
  );

  function automatic int g2b(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return int'(b);
  endfunction

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input logic [1:0] a);
    if (a == 2'b10) return code(v % 10);
    if (a == 2'b01) return (v >= 10) ? code(v / 10) : 7'b0000000;
    return 7'b0000000;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_display(input int v, input string nm);
    logic [6:0] s0, s1;
    bit g0, g1;
    int bad;
    g0 = 0; g1 = 0; bad = 0; s0 = '0; s1 = '0;
    for (int i = 0; i < 36; i++) begin
      step(1);
      if (an == 2'b10) begin s0 = seg; g0 = 1; end
      else if (an == 2'b01) begin s1 = seg; g1 = 1; end
      else bad++;
    end
    checks++;
    if (bad != 0 || !g0 || !g1) begin
      failures++;
      $display("FAIL %s_an_onehot bad=%0d seen0=%0d seen1=%0d required bad=0 both seen", nm, bad, g0, g1);
    end
    checks++;
    if (s0 !== exp_seg(v, 2'b10)) begin
      failures++;
      $display("FAIL %s_digit0 got=%b required=%b", nm, s0, exp_seg(v, 2'b10));
    end
    checks++;
    if (s1 !== exp_seg(v, 2'b01)) begin
      failures++;
      $display("FAIL %s_digit1 got=%b required=%b", nm, s1, exp_seg(v, 2'b01));
    end
  endtask

  task automatic accept_and_check(input logic [3:0] g, input logic [3:0] old_led, input string nm);
    int e, d;
    gray_in = g;
    exp_led_q.push_back(g2b(g));
    exp_disp_q.push_back(g2b(g));
    step(6);
    checks++;
    if (led !== old_led) begin
      failures++;
      $display("FAIL %s_led_early got=%b required=%b", nm, led, old_led);
    end
    step(1);
    e = exp_led_q.pop_front();
    checks++;
    if (led !== 4'(e)) begin
      failures++;
      $display("FAIL %s_led got=%b required=%b", nm, led, 4'(e));
    end
    step(4);
    checks++;
    if (bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_vld_early got=%b required=0", nm, bcd_valid);
    end
    step(1);
    checks++;
    if (bcd_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_vld_latency got=%b required=1", nm, bcd_valid);
    end
    step(1);
    checks++;
    if (bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_vld_pulse got=%b required=0", nm, bcd_valid);
    end
    d = exp_disp_q.pop_front();
    check_display(d, nm);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    gray_in = '0;
    step(3);
    checks++;
    if (led !== 4'b0 || an !== 2'b11 || seg !== 7'b0 || bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs led=%b an=%b seg=%b vld=%b required 0000 11 0000000 0", led, an, seg, bcd_valid);
    end
    rst = 1'b0;
    step(2);
    checks++;
    if (an !== 2'b10 || seg !== 7'b1111110) begin
      failures++;
      $display("FAIL reset_digit0 an=%b seg=%b required an=10 seg=1111110", an, seg);
    end
    n = 0;
    while (an !== 2'b01 && n < 40) begin step(1); n++; end
    checks++;
    if (n >= 40 || seg !== 7'b0) begin
      failures++;
      $display("FAIL reset_digit1_blank an=%b seg=%b required an=01 seg=0000000", an, seg);
    end
  endtask

  task automatic test_glitch;
    bit saw;
    saw = 0;
    gray_in = 4'b0011;
    for (int i = 0; i < 3; i++) begin step(1); saw |= bcd_valid; end
    gray_in = 4'b0000;
    for (int i = 0; i < 20; i++) begin step(1); saw |= bcd_valid; end
    checks++;
    if (led !== 4'b0000) begin
      failures++;
      $display("FAIL glitch_led got=%b required=0000", led);
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL glitch_vld got=1 required=0");
    end
  endtask

  task automatic test_scan_dwell;
    int n, c1, c0;
    n = 0;
    while (an !== 2'b10 && n < 40) begin step(1); n++; end
    while (an !== 2'b01 && n < 80) begin step(1); n++; end
    c1 = 0;
    while (an === 2'b01 && c1 < 40) begin step(1); c1++; end
    c0 = 0;
    while (an === 2'b10 && c0 < 40) begin step(1); c0++; end
    checks++;
    if (n >= 80 || c1 != 8 || c0 != 8) begin
      failures++;
      $display("FAIL scan_dwell digit1=%0d digit0=%0d required 8 and 8", c1, c0);
    end
  endtask

  task automatic test_back_to_back;
    int pulses, e;
    pulses = 0;
    exp_disp_q.push_back(g2b(4'b0010));
    exp_disp_q.push_back(g2b(4'b1011));
    gray_b = 4'b0010;
    step(2);
    gray_b = 4'b0110;
    step(2);
    checks++;
    if (led_b !== 4'(g2b(4'b0010))) begin
      failures++;
      $display("FAIL b2b_led1 got=%b required=%b", led_b, 4'(g2b(4'b0010)));
    end
    gray_b = 4'b1011;
    step(2);
    checks++;
    if (led_b !== 4'(g2b(4'b0110))) begin
      failures++;
      $display("FAIL b2b_led2 got=%b required=%b", led_b, 4'(g2b(4'b0110)));
    end
    step(2);
    checks++;
    if (led_b !== 4'(g2b(4'b1011))) begin
      failures++;
      $display("FAIL b2b_led3 got=%b required=%b", led_b, 4'(g2b(4'b1011)));
    end
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bcd_valid_b) begin
        pulses++;
        step(1);
        if (exp_disp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b2b_extra_pulse got=%0d required=2", pulses);
        end else begin
          e = exp_disp_q.pop_front();
          checks++;
          if (seg_b !== exp_seg(e, an_b)) begin
            failures++;
            $display("FAIL b2b_disp an=%b got=%b required=%b", an_b, seg_b, exp_seg(e, an_b));
          end
        end
      end
    end
    checks++;
    if (pulses != 2 || exp_disp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d required=2", pulses);
    end
  endtask

  task automatic test_reset_mid;
    gray_in = 4'b1111;
    step(8);
    checks++;
    if (led !== 4'b1010) begin
      failures++;
      $display("FAIL rmid_led_pre got=%b required=1010", led);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0 || an !== 2'b11 || seg !== 7'b0 || bcd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_outputs led=%b an=%b seg=%b vld=%b required 0000 11 0000000 0", led, an, seg, bcd_valid);
    end
    step(2);
    rst = 1'b0;
    accept_and_check(4'b1111, 4'b0000, "rmid");
  endtask

  initial begin
    test_reset();
    test_glitch();
    accept_and_check(4'b1111, 4'b0000, "val10");
    accept_and_check(4'b1000, 4'b1010, "val15");
    accept_and_check(4'b0111, 4'b1111, "val5");
    test_scan_dwell();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
